mem_port_arbiter: RTL and testbench

Shares the single-ported memory between two requesters: instruction fetch (if_*) and data load/store (dm_*, issued for ldm/stm). Each requester gets a req/ack handshake. The arbiter drives the memory strobes, waits for mem_ready, and returns read data. It sits between control_unit and the memory, replacing direct drive of mem_read/mem_write/d_addr/d_bus by the control unit.

---
 rtl/cpu_bus_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 23 ++
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared bus definitions for the CPU memory port: arbiter FSM states, grant ids
// and the timeout/error defaults also used by control_unit.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

  localparam int          TIMEOUT_DEFAULT  = 15;
  localparam logic [15:0] ERR_DATA_DEFAULT = 16'hDEAD;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin pick: a lone request wins outright, and on a tie
// the side that was not granted last time wins.
module rr_arbiter2
  import cpu_bus_pkg::*;
(
  input  logic if_req,
  input  logic dm_req,
  input  logic last_grant,
  output logic valid,
  output logic grant
);

  always_comb begin
    valid = if_req | dm_req;
    grant = GNT_IF;
    if (if_req && dm_req) begin
      grant = ~last_grant;
    end else if (dm_req) begin
      grant = GNT_DM;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported memory between instruction fetch and data load/store,
// with registered strobes, a per-access timeout and one-cycle completion acks.
module mem_port_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter int                TIMEOUT  = TIMEOUT_DEFAULT,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              timeout_err
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  arb_state_e        state_reg, state_next;
  logic              last_grant_reg, last_grant_next;
  logic [7:0]        tmo_cnt_reg, tmo_cnt_next;
  logic              if_ack_reg, if_ack_next;
  logic              dm_ack_reg, dm_ack_next;
  logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0] dm_rdata_reg, dm_rdata_next;
  logic              mem_read_reg, mem_read_next;
  logic              mem_write_reg, mem_write_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic              timeout_err_reg, timeout_err_next;

  logic arb_valid;
  logic arb_grant;
  logic tmo_hit;
  logic grant_we;

  rr_arbiter2 u_rr (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .last_grant (last_grant_reg),
    .valid      (arb_valid),
    .grant      (arb_grant)
  );

  // Fires on the TIMEOUT-th consecutive ACCESS cycle without mem_ready.
  assign tmo_hit  = !mem_ready && (tmo_cnt_reg == TMO_LAST);
  assign grant_we = (arb_grant == GNT_DM) && dm_we;

  always_comb begin
    state_next       = state_reg;
    last_grant_next  = last_grant_reg;
    tmo_cnt_next     = tmo_cnt_reg;
    if_ack_next      = 1'b0;
    dm_ack_next      = 1'b0;
    if_rdata_next    = if_rdata_reg;
    dm_rdata_next    = dm_rdata_reg;
    mem_read_next    = mem_read_reg;
    mem_write_next   = mem_write_reg;
    mem_addr_next    = mem_addr_reg;
    mem_wdata_next   = mem_wdata_reg;
    timeout_err_next = timeout_err_reg;

    case (state_reg)
      ST_IDLE: begin
        if (arb_valid) begin
          // The granted id doubles as the round-robin history bit.
          last_grant_next = arb_grant;
          tmo_cnt_next    = 8'd0;
          mem_read_next   = !grant_we;
          mem_write_next  = grant_we;
          mem_addr_next   = (arb_grant == GNT_DM) ? dm_addr : if_addr;
          if (arb_grant == GNT_DM) begin
            mem_wdata_next = dm_wdata;
          end
          state_next = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (!mem_ready) begin
          tmo_cnt_next = tmo_cnt_reg + 8'd1;
        end
        if (mem_ready || tmo_hit) begin
          mem_read_next  = 1'b0;
          mem_write_next = 1'b0;
          if (!mem_ready) begin
            timeout_err_next = 1'b1;
          end
          if (last_grant_reg == GNT_DM) begin
            dm_ack_next = 1'b1;
            if (!mem_write_reg) begin
              dm_rdata_next = mem_ready ? mem_rdata : ERR_DATA;
            end
          end else begin
            if_ack_next   = 1'b1;
            if_rdata_next = mem_ready ? mem_rdata : ERR_DATA;
          end
          state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next     = ST_IDLE;
        mem_read_next  = 1'b0;
        mem_write_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      last_grant_reg  <= GNT_DM;
      tmo_cnt_reg     <= 8'd0;
      if_ack_reg      <= 1'b0;
      dm_ack_reg      <= 1'b0;
      if_rdata_reg    <= '0;
      dm_rdata_reg    <= '0;
      mem_read_reg    <= 1'b0;
      mem_write_reg   <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      last_grant_reg  <= last_grant_next;
      tmo_cnt_reg     <= tmo_cnt_next;
      if_ack_reg      <= if_ack_next;
      dm_ack_reg      <= dm_ack_next;
      if_rdata_reg    <= if_rdata_next;
      dm_rdata_reg    <= dm_rdata_next;
      mem_read_reg    <= mem_read_next;
      mem_write_reg   <= mem_write_next;
      mem_addr_reg    <= mem_addr_next;
      mem_wdata_reg   <= mem_wdata_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  assign if_ack      = if_ack_reg;
  assign dm_ack      = dm_ack_reg;
  assign if_rdata    = if_rdata_reg;
  assign dm_rdata    = dm_rdata_reg;
  assign mem_read    = mem_read_reg;
  assign mem_write   = mem_write_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change and outputs are sampled
// on the falling edge, so each tick() advances exactly one clock cycle.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic [15:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        dm_ack;
  logic [15:0] dm_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        timeout_err;

  int n_cmp;
  int n_bad;
  int n_excl;

  mem_port_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_ack      (if_ack),
    .if_rdata    (if_rdata),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_ack      (dm_ack),
    .dm_rdata    (dm_rdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Mutual-exclusion watch over the whole run.
  always @(negedge clk) begin
    if (rst_n && ((if_ack && dm_ack) || (mem_read && mem_write))) n_excl++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int strobe_cycles;
    logic [15:0] held;
    logic [15:0] exp_addr;
    n_cmp = 0; n_bad = 0; n_excl = 0;
    rst_n = 1'b0; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0;
    dm_addr = 0; dm_wdata = 0; mem_rdata = 0; mem_ready = 0;
    tick();
    chk("rst_mem_read", mem_read, 0);
    chk("rst_acks", {if_ack, dm_ack}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_terr", timeout_err, 0);
    rst_n = 1'b1;
    tick();

    // Round-robin tie straight out of reset: IF, DM, IF, DM.
    if_req = 1; if_addr = 16'h0100; dm_req = 1; dm_we = 0; dm_addr = 16'h0300;
    for (int i = 0; i < 4; i++) begin
      exp_addr = (i % 2 == 0) ? 16'h0100 : 16'h0300;
      tick();
      chk($sformatf("tie%0d_addr", i), mem_addr, exp_addr);
      chk($sformatf("tie%0d_rd", i), mem_read, 1);
      mem_ready = 1; mem_rdata = 16'hA000 + 16'(i);
      tick();
      mem_ready = 0;
      chk($sformatf("tie%0d_acks", i), {if_ack, dm_ack}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (i % 2 == 0) chk($sformatf("tie%0d_ifd", i), if_rdata, 16'hA000 + 16'(i));
      else            chk($sformatf("tie%0d_dmd", i), dm_rdata, 16'hA000 + 16'(i));
      if (i == 3) begin if_req = 0; dm_req = 0; end
      tick();
    end

    // Single fetch with immediate ready: strobe in cycle 1, ack in cycle 2.
    do_reset();
    if_req = 1; if_addr = 16'h0010;
    tick();
    chk("f_rd", mem_read, 1);
    chk("f_addr", mem_addr, 16'h0010);
    mem_ready = 1; mem_rdata = 16'h1234;
    tick();
    if_req = 0; mem_ready = 0;
    chk("f_ack", if_ack, 1);
    chk("f_data", if_rdata, 16'h1234);
    chk("f_rd_off", mem_read, 0);
    tick();
    chk("f_ack_1cyc", if_ack, 0);
    chk("f_data_hold", if_rdata, 16'h1234);

    // Load to seed dm_rdata, then a store with three wait states.
    dm_req = 1; dm_we = 0; dm_addr = 16'h0020;
    tick();
    mem_ready = 1; mem_rdata = 16'h5A5A;
    tick();
    dm_req = 0; mem_ready = 0;
    tick();
    held = 16'h5A5A;
    dm_req = 1; dm_we = 1; dm_addr = 16'h0200; dm_wdata = 16'hBEEF;
    strobe_cycles = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (mem_write && mem_wdata == 16'hBEEF && mem_addr == 16'h0200 && !mem_read)
        strobe_cycles++;
      mem_ready = (c == 3);
    end
    chk("st_strobe_cycles", strobe_cycles, 4);
    tick();
    dm_req = 0; dm_we = 0; mem_ready = 0;
    chk("st_ack", dm_ack, 1);
    chk("st_wr_off", mem_write, 0);
    chk("st_rdata_kept", dm_rdata, held);
    tick();

    // Load with no ready at all: aborts after 15 cycles with the error word.
    dm_req = 1; dm_addr = 16'h0400;
    strobe_cycles = 0;
    for (int c = 0; c < 20 && !dm_ack; c++) begin
      tick();
      if (mem_read) strobe_cycles++;
    end
    chk("to_strobe_cycles", strobe_cycles, 15);
    chk("to_ack", dm_ack, 1);
    chk("to_rdata", dm_rdata, 16'hDEAD);
    chk("to_err", timeout_err, 1);
    dm_req = 0;
    tick();
    if_req = 1; if_addr = 16'h0030;
    tick();
    mem_ready = 1; mem_rdata = 16'h7777;
    tick();
    if_req = 0; mem_ready = 0;
    chk("to_ok_ack", if_ack, 1);
    chk("to_err_sticky", timeout_err, 1);
    tick();

    // Reset in the middle of an access drops everything asynchronously.
    if_req = 1; if_addr = 16'h0040;
    tick();
    chk("rm_rd_pre", mem_read, 1);
    #2;
    rst_n = 1'b0;
    if_req = 0;
    #1;
    chk("rm_async_rd", mem_read, 0);
    chk("rm_async_err", timeout_err, 0);
    tick();
    rst_n = 1'b1;
    strobe_cycles = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (if_ack || dm_ack || mem_read || mem_write) strobe_cycles++;
    end
    chk("rm_quiet", strobe_cycles, 0);
    if_req = 1; if_addr = 16'h0044;
    tick();
    chk("rm_reissue_addr", mem_addr, 16'h0044);
    mem_ready = 1; mem_rdata = 16'h4444;
    tick();
    if_req = 0; mem_ready = 0;
    chk("rm_reissue_data", {15'd0, if_ack, if_rdata}, {15'd0, 1'b1, 16'h4444});
    tick();

    // Disturb inputs during ACCESS and pulse ready while idle.
    dm_req = 1; dm_we = 0; dm_addr = 16'h0600;
    tick();
    dm_req = 0; dm_addr = 16'h0700;
    tick();
    chk("dist_addr", mem_addr, 16'h0600);
    chk("dist_rd", mem_read, 1);
    mem_ready = 1; mem_rdata = 16'h5555;
    tick();
    mem_ready = 0;
    chk("dist_ack", {dm_ack, dm_rdata}, {1'b1, 16'h5555});
    tick();
    mem_ready = 1; mem_rdata = 16'h9999;
    strobe_cycles = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (if_ack || dm_ack || mem_read || mem_write) strobe_cycles++;
    end
    mem_ready = 0;
    chk("dist_idle_quiet", strobe_cycles, 0);
    chk("dist_rdata_kept", dm_rdata, 16'h5555);

    chk("exclusive", n_excl, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
